pipe_stage_skid_reg: RTL

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_sat_counter.sv | 34 +++
 rtl/pipe_stage_skid_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the two-entry pipeline boundary register.
// Ports: none (package only).
// Holds the occupancy state encoding used by pipe_stage_skid_reg.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main only, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Largest number of entries a single flush can discard.
    localparam int unsigned MAX_SQUASH_PER_FLUSH = 2;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating counter that adds 0, 1 or 2 per cycle and never wraps.
// Latency: o_cnt reflects an increment on the cycle after the edge that applied it.
// Backpressure: none; an increment is applied every cycle it is presented.
// Ports: i_clk/i_reset (sync, active-high), i_add (0..2), o_cnt (count value).
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_add,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W:0] MAX_CNT = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    // One extra bit of headroom so an overshoot past the max is visible.
    assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(i_add);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_sum > MAX_CNT) begin
            r_cnt <= MAX_CNT[CNT_W-1:0];
        end else begin
            r_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry valid/ready pipeline register (main + skid) with flush and squash counting.
// Latency: 1 cycle from in_fire to out_valid when empty, or when one entry drains the same cycle.
// Backpressure: in_ready comes from registered state only; the skid entry absorbs one
//               transfer when out_ready drops, so out_ready never reaches in_ready combinationally.
// Ports: clk/reset (sync, active-high), flush, in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream, squash_cnt (saturating discarded-entry count).
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  squash_cnt
);

    pipe_state_t       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [1:0]        w_squash_add;

    assign in_ready   = (r_state != FULL) & ~reset;
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Entries held at the start of a flush cycle, minus the one that still
    // leaves through the output port that same cycle.
    always_comb begin
        w_squash_add = 2'd0;
        if (flush) begin
            case (r_state)
                ONE:     w_squash_add = out_ready ? 2'd0 : 2'd1;
                FULL:    w_squash_add = out_ready ? 2'd1 : 2'd2;
                default: w_squash_add = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // Flush outranks any transfer: the incoming entry is dropped.
            r_state <= EMPTY;
            if (CLEAR_DATA != 0) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= in_data;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_data;
                    end else if (w_in_fire) begin
                        r_skid  <= in_data;
                        r_state <= FULL;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_squash_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_add   (w_squash_add),
        .o_cnt   (squash_cnt)
    );

endmodule : pipe_stage_skid_reg
